// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit queue: sequencer states, ASCII constants, default depth.
// UART_TXQ_CRLF_EN adds the LF state used to follow each transmitted CR with an LF.
package uart_pkg;

  localparam int unsigned DEPTH_LOG2_DEFAULT = 4;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

`ifdef UART_TXQ_CRLF_EN
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_SEND = 2'b01,
    ST_WAIT = 2'b10,
    ST_LF   = 2'b11
  } tx_state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_SEND = 2'b01,
    ST_WAIT = 2'b10
  } tx_state_t;
`endif

endpackage

// File: rtl/sync_fifo_byte.sv
// Byte-wide circular FIFO with a separate count register, registered full/empty and sticky overflow.
// Full is judged on the registered count, so a pop in the same cycle does not free a slot for a write.
module sync_fifo_byte
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = DEPTH_LOG2_DEFAULT
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_wr_en,
  input  logic [7:0]            i_wr_data,
  input  logic                  i_rd_en,
  output logic [7:0]            o_rd_data,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [DEPTH_LOG2:0]   o_count,
  output logic                  o_overflow
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

  logic [7:0]            r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  r_full;
  logic                  r_empty;
  logic                  r_overflow;

  logic                  w_push;
  logic                  w_pop;
  logic [DEPTH_LOG2:0]   w_count_nxt;

  assign w_push = i_wr_en && !r_full;
  assign w_pop  = i_rd_en && !r_empty;

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop) begin
      w_count_nxt = r_count + CNT_ONE;
    end else if (w_pop && !w_push) begin
      w_count_nxt = r_count - CNT_ONE;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      r_count    <= w_count_nxt;
      r_full     <= (w_count_nxt == CNT_FULL);
      r_empty    <= (w_count_nxt == '0);
      r_overflow <= r_overflow || (i_wr_en && r_full);
    end
  end

  assign o_rd_data  = r_mem[r_rd_ptr];
  assign o_full     = r_full;
  assign o_empty    = r_empty;
  assign o_count    = r_count;
  assign o_overflow = r_overflow;

endmodule

// File: rtl/uart_tx_queue.sv
// Byte queue plus transmit sequencer draining it over the tx_dv/tx_ready/tx_done handshake.
// Define UART_TXQ_CRLF_EN to insert an LF after every transmitted CR.
module uart_tx_queue
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = DEPTH_LOG2_DEFAULT
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_wr_en,
  input  logic [7:0]            i_wr_data,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [DEPTH_LOG2:0]   o_count,
  output logic                  o_overflow,
  output logic                  o_tx_dv,
  output logic [7:0]            o_tx_byte,
  input  logic                  i_tx_ready,
  input  logic                  i_tx_done,
  output logic [1:0]            o_state_out
);

  tx_state_t  r_state;
  tx_state_t  w_state_nxt;
  logic       r_tx_dv;
  logic [7:0] r_tx_byte;

  logic       w_pop;
  logic       w_start;
  logic [7:0] w_next_byte;
  logic [7:0] w_rd_data;
  logic       w_empty;

  sync_fifo_byte #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_wr_en    (i_wr_en),
    .i_wr_data  (i_wr_data),
    .i_rd_en    (w_pop),
    .o_rd_data  (w_rd_data),
    .o_full     (o_full),
    .o_empty    (w_empty),
    .o_count    (o_count),
    .o_overflow (o_overflow)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_start     = 1'b0;
    w_next_byte = w_rd_data;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty && i_tx_ready) begin
          w_pop       = 1'b1;
          w_start     = 1'b1;
          w_state_nxt = ST_SEND;
        end
      end
      // tx_done arriving during the start pulse belongs to the previous byte
      ST_SEND: w_state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (i_tx_done) begin
`ifdef UART_TXQ_CRLF_EN
          w_state_nxt = (r_tx_byte == ASCII_CR) ? ST_LF : ST_IDLE;
`else
          w_state_nxt = ST_IDLE;
`endif
        end
      end
`ifdef UART_TXQ_CRLF_EN
      ST_LF: begin
        if (i_tx_ready) begin
          w_start     = 1'b1;
          w_next_byte = ASCII_LF;
          w_state_nxt = ST_SEND;
        end
      end
`endif
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= ST_IDLE;
      r_tx_dv   <= 1'b0;
      r_tx_byte <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_tx_dv <= w_start;
      if (w_start) begin
        r_tx_byte <= w_next_byte;
      end
    end
  end

  assign o_empty     = w_empty;
  assign o_tx_dv     = r_tx_dv;
  assign o_tx_byte   = r_tx_byte;
  assign o_state_out = r_state;

endmodule
